ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_sync_edge.sv | 31 +++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states,
// default bus timing at 25 MHz and common keyboard command codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  // Width of the edge / inhibit timer; large enough for the 15 ms first-edge limit.
  localparam int unsigned PS2_TIMER_W = 19;

  localparam int unsigned PS2_INHIBIT_CYCLES    = 2500;    // 100 us
  localparam int unsigned PS2_FIRST_EDGE_CYCLES = 375000;  // 15 ms
  localparam int unsigned PS2_BIT_CYCLES        = 50000;   // 2 ms

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] byte_i);
    return ~^byte_i;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one PS/2 line plus a falling-edge detector on the
// synchronised level. Flops reset high, matching an idle (released) bus.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronise the asynchronous line and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a byte plus odd parity and stop out on device clock edges, samples the
// device ACK and reports done / ack_err, or aborts with a timeout pulse.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES    = PS2_INHIBIT_CYCLES,
  parameter int unsigned FIRST_EDGE_CYCLES = PS2_FIRST_EDGE_CYCLES,
  parameter int unsigned BIT_CYCLES        = PS2_BIT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam logic [PS2_TIMER_W-1:0] INH_LAST   = PS2_TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_TIMER_W-1:0] FIRST_LAST = PS2_TIMER_W'(FIRST_EDGE_CYCLES - 1);
  localparam logic [PS2_TIMER_W-1:0] BIT_LAST   = PS2_TIMER_W'(BIT_CYCLES - 1);

  ps2_tx_state_e            state_q, state_d;
  logic [PS2_TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               data_q, data_d;
  logic                     parity_q, parity_d;
  logic                     c_oe_q, c_oe_d;
  logic                     d_oe_q, d_oe_d;
  logic                     done_q, done_d;
  logic                     ack_err_q, ack_err_d;
  logic                     timeout_q, timeout_d;
  logic                     tx_ready_q, tx_ready_d;

  logic                     c_level, c_fall;
  logic                     d_level, unused_d_fall;
  logic [PS2_TIMER_W-1:0]   timer_limit;
  logic                     timer_expired;

  ps2_sync_edge u_sync_c (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2c_in),
    .level_o (c_level),
    .fall_o  (c_fall)
  );

  ps2_sync_edge u_sync_d (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2d_in),
    .level_o (d_level),
    .fall_o  (unused_d_fall)
  );

  // The device gets longer to produce its first clock than between later clocks.
  assign timer_limit   = (state_q == REQ) ? FIRST_LAST : BIT_LAST;
  assign timer_expired = (timer_q == timer_limit);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      c_oe_q     <= 1'b0;
      d_oe_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      c_oe_q     <= c_oe_d;
      d_oe_q     <= d_oe_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      timeout_q  <= timeout_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Next-state and output decode; timeout abort takes priority, then device edges
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    c_oe_d    = c_oe_q;
    d_oe_d    = d_oe_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    timeout_d = 1'b0;

    if (timeout_q) begin
      // Lines were already released with the pulse; now go back to idle.
      state_d   = IDLE;
      timer_d   = '0;
      bit_cnt_d = '0;
      c_oe_d    = 1'b0;
      d_oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d   = '0;
          bit_cnt_d = '0;
          c_oe_d    = 1'b0;
          d_oe_d    = 1'b0;
          if (tx_valid && tx_ready_q) begin
            data_d    = tx_data;
            parity_d  = ps2_odd_parity(tx_data);
            ack_err_d = 1'b0;
            c_oe_d    = 1'b1;
            state_d   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer_q == INH_LAST) begin
            // Request-to-send: data low as start bit, clock released.
            c_oe_d  = 1'b0;
            d_oe_d  = 1'b1;
            timer_d = '0;
            state_d = REQ;
          end
        end
        default: begin
          if (c_fall) begin
            timer_d = '0;
            case (state_q)
              REQ: begin
                d_oe_d    = ~data_q[0];
                bit_cnt_d = 3'd1;
                state_d   = DATA;
              end
              DATA: begin
                d_oe_d    = ~data_q[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
                end
              end
              PARITY: begin
                d_oe_d  = ~parity_q;
                state_d = STOP;
              end
              STOP: begin
                d_oe_d  = 1'b0;
                state_d = ACK;
              end
              ACK: begin
                // Device pulls data low to acknowledge.
                ack_err_d = d_level;
                state_d   = WAIT_IDLE;
              end
              default: begin
              end
            endcase
          end else if ((state_q == WAIT_IDLE) && c_level && d_level) begin
            done_d  = 1'b1;
            timer_d = '0;
            state_d = IDLE;
          end else if (timer_expired) begin
            timeout_d = 1'b1;
            c_oe_d    = 1'b0;
            d_oe_d    = 1'b0;
          end
        end
      endcase
    end

    tx_ready_d = (state_d == IDLE);
  end

  assign tx_ready = tx_ready_q;
  assign ps2c_oe  = c_oe_q;
  assign ps2d_oe  = d_oe_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus model, a behavioural PS/2 device,
// a queue of expected frame bits and a queue of expected transfer outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 20;
  localparam int FIRST = 300;
  localparam int BITC  = 100;
  localparam int HP    = 10;   // device clock half period in system clocks

  localparam int KIND_ACK  = 0;
  localparam int KIND_NACK = 1;
  localparam int KIND_TO   = 2;

  typedef struct {
    int kind;
    int gap;
  } outcome_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2c_oe, ps2d_oe, busy, done, ack_err, timeout;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = dev_c & ~ps2c_oe;
  assign ps2d_line = dev_d & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES    (INH),
    .FIRST_EDGE_CYCLES (FIRST),
    .BIT_CYCLES        (BITC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .ps2c_in  (ps2c_line),
    .ps2d_in  (ps2d_line),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .timeout  (timeout)
  );

  int       n_checks = 0;
  int       n_fail   = 0;
  bit       exp_bits[$];
  outcome_t exp_out[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_outcome(input int kind, input int gap);
    outcome_t o;
    o.kind = kind;
    o.gap  = gap;
    exp_out.push_back(o);
  endtask

  // Bus order: start 0, data LSB first, odd parity, stop 1.
  task automatic push_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
  endtask

  function automatic int pop_bit();
    if (exp_bits.size() == 0) return 2;
    return int'(exp_bits.pop_front());
  endfunction

  // Offer one byte and hold tx_valid until the transfer has started.
  task automatic start_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    push_frame(b);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1;
        break;
      end
    end
    tx_valid = 1'b0;
    check_eq("byte_accepted", int'(ok), 1);
  endtask

  // Behavioural device: waits for request-to-send, generates n_edges clocks,
  // samples host data on each rising clock, optionally ACKs at edge 11.
  task automatic device_xfer(input int n_edges, input bit give_ack);
    bit ok;
    ok = 0;
    for (int i = 0; i < INH + 200; i++) begin
      @(negedge clk);
      if (ps2d_oe && !ps2c_oe) begin
        ok = 1;
        break;
      end
    end
    check_eq("rts_seen", int'(ok), 1);
    if (ok) begin
      check_eq("start_bit", int'(ps2d_line), pop_bit());
      for (int e = 1; e <= n_edges; e++) begin
        if (e == 11 && give_ack) dev_d = 1'b0;
        repeat (HP) @(negedge clk);
        dev_c = 1'b0;
        repeat (HP) @(negedge clk);
        dev_c = 1'b1;
        if (e <= 10) check_eq($sformatf("frame_bit%0d", e), int'(ps2d_line), pop_bit());
      end
      dev_d = 1'b1;
    end
  endtask

  task automatic wait_outcomes(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_out.size() == 0) break;
      @(negedge clk);
    end
    check_eq("outcomes_drained", exp_out.size(), 0);
    exp_out.delete();
  endtask

  // Monitor state
  int       neg_cyc = 0;
  int       d_chg_cyc = 0;
  int       inh_run = 0;
  int       last_inh = 0;
  int       viol_oe = 0;
  int       viol_ready = 0;
  int       starts = 0;
  logic     d_oe_prev = 1'b0;
  logic     busy_prev = 1'b0;
  bit       ready_next = 0;
  outcome_t mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      neg_cyc++;
      if (!rst) begin
        if (ready_next) begin
          check_eq("ready_after_timeout", int'(tx_ready), 1);
          ready_next = 0;
        end
        if (!busy && (ps2c_oe || ps2d_oe)) viol_oe++;
        if (busy && tx_ready) viol_ready++;
        if (busy && !busy_prev) starts++;
        if (done || timeout) begin
          if (exp_out.size() == 0) begin
            check_eq(done ? "unexpected_done" : "unexpected_timeout", 1, 0);
          end else begin
            mon_exp = exp_out.pop_front();
            if (timeout) begin
              check_eq("outcome_timeout", KIND_TO, mon_exp.kind);
              check_eq("timeout_gap", neg_cyc - d_chg_cyc, mon_exp.gap);
              check_eq("oe_at_timeout", int'({ps2c_oe, ps2d_oe}), 0);
              check_eq("no_done_with_timeout", int'(done), 0);
              ready_next = 1;
            end else begin
              check_eq("outcome_done", ack_err ? KIND_NACK : KIND_ACK, mon_exp.kind);
            end
          end
          $display("[%0t] transfer end: done=%0b timeout=%0b ack_err=%0b", $time, done, timeout, ack_err);
        end
      end
      // Track after the outcome check so a release at timeout does not reset the gap.
      if (ps2d_oe !== d_oe_prev) d_chg_cyc = neg_cyc;
      d_oe_prev = ps2d_oe;
      busy_prev = busy;
      if (ps2c_oe) begin
        inh_run++;
      end else begin
        if (inh_run != 0) last_inh = inh_run;
        inh_run = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  int starts_before;
  bit seen;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", int'({tx_ready, ps2c_oe, ps2d_oe, busy, done, ack_err, timeout}), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", int'(tx_ready), 1);

    // Set-LED command with ACK; 8'hED has six ones so the parity bit is 1.
    expect_outcome(KIND_ACK, 0);
    start_byte(CMD_SET_LED);
    device_xfer(11, 1);
    wait_outcomes(200);
    check_eq("inhibit_len", last_inh, INH);
    check_eq("frame_bits_left", exp_bits.size(), 0);

    // All-zero byte, device withholds ACK.
    expect_outcome(KIND_NACK, 0);
    start_byte(8'h00);
    device_xfer(11, 0);
    wait_outcomes(200);
    check_eq("frame_bits_left", exp_bits.size(), 0);

    // Device never clocks after request-to-send.
    expect_outcome(KIND_TO, FIRST);
    start_byte(CMD_RESET);
    wait_outcomes(INH + FIRST + 50);
    exp_bits.delete();
    repeat (3) @(negedge clk);

    // Device stops after edge 5 (bit 4 of 8'hED differs from bit 3, so the line toggles there).
    expect_outcome(KIND_TO, BITC);
    start_byte(CMD_SET_LED);
    device_xfer(5, 1);
    wait_outcomes(BITC + 50);
    exp_bits.delete();
    repeat (3) @(negedge clk);

    // Reset in the middle of the data phase, then a normal transfer.
    start_byte(CMD_ENABLE);
    device_xfer(4, 1);
    check_eq("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_release", int'({ps2c_oe, ps2d_oe, busy, tx_ready, done, timeout}), 0);
    rst = 1'b0;
    exp_bits.delete();
    repeat (5) @(negedge clk);
    expect_outcome(KIND_ACK, 0);
    start_byte(CMD_RESET);
    device_xfer(11, 1);
    wait_outcomes(200);
    check_eq("frame_bits_left", exp_bits.size(), 0);

    // tx_valid held across a whole transfer: one byte per idle visit.
    starts_before = starts;
    push_frame(CMD_ENABLE);
    push_frame(CMD_ENABLE);
    expect_outcome(KIND_ACK, 0);
    expect_outcome(KIND_ACK, 0);
    tx_data  = CMD_ENABLE;
    tx_valid = 1'b1;
    device_xfer(11, 1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1;
        break;
      end
    end
    check_eq("idle_between", int'(seen), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        break;
      end
    end
    check_eq("second_accept", int'(seen), 1);
    tx_valid = 1'b0;
    device_xfer(11, 1);
    wait_outcomes(200);
    repeat (5) @(negedge clk);
    check_eq("held_valid_starts", starts - starts_before, 2);
    check_eq("frame_bits_left", exp_bits.size(), 0);

    check_eq("oe_outside_transfer", viol_oe, 0);
    check_eq("ready_while_busy", viol_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
